muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative 64-bit multiply/divide execution unit for the LEGv8 datapath.
- Consumes the two register-file read buses (dataRn, dataRm) and the destination index.
- Computes MUL, UDIV or SDIV over a fixed number of cycles.
- Presents result, Rd and a one-cycle write strobe that drive the register file's dataWrite/Rd/regWR write-back port.

Parameters:
- WIDTH, 64, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only in IDLE.
- op  input  2  operation: 00 MUL, 01 UDIV, 10 SDIV, 11 reserved.
- dataRn  input  WIDTH  operand A (dividend/multiplicand).
- dataRm  input  WIDTH  operand B (divisor/multiplier).
- Rd  input  5  destination register index, captured at accept.
- busy  output  1  high while state != IDLE.
- done  output  1  one-cycle pulse when result is valid.
- result  output  WIDTH  computed value; holds until next done.
- RdOut  output  5  captured Rd; holds until next accept.
- regWR  output  1  write-back strobe; equals done.

Behaviour:
- Clocking/reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state IDLE, busy=0, done=0, regWR=0, result=0, RdOut=0, counter=0.
- Reset mid-operation: aborts the operation; no done/regWR pulse is produced for it.
- States:
  - IDLE: start=1 at a rising edge -> latch op, dataRn, dataRm, Rd; counter=0; go to RUN. start=0 -> stay.
  - RUN: one iteration per cycle; counter increments; after iteration WIDTH-1 (counter==WIDTH-1) go to DONE.
  - DONE: done=1 and regWR=1 for exactly this cycle; result/RdOut valid; next edge -> IDLE.
- Latency: fixed for every op. Accept edge E0 -> RUN during cycles 1..WIDTH -> done high in cycle WIDTH+1 (65 cycles at default).
- Back-to-back: start is first acceptable in the cycle after DONE. Minimum issue interval is WIDTH+2 cycles.
- start while busy: ignored, no queuing. Operand inputs may change freely after accept.
- Throughout a run:
  - busy is high from the cycle after accept through the DONE cycle inclusive.
  - result keeps its previous value until DONE.
- MUL:
  - Shift-add.
  - result = low WIDTH bits of A*B; identical for signed and unsigned operands.
- UDIV:
  - Restoring division, one quotient bit per iteration, MSB first.
  - result = floor(A/B) unsigned.
- SDIV:
  - Divide |A| by |B| as unsigned.
  - Negate the quotient if the sign bits of A and B differ; truncates toward zero.
  - |INT_MIN| is treated as unsigned 2^(WIDTH-1).
  - INT_MIN / -1 = INT_MIN (wraps), no exception.
- Divide by zero (UDIV/SDIV, B==0): result=0, normal latency, regWR still pulses.
- Reserved op 11: result=0, normal latency, regWR pulses.
- Rd==31: no special handling; the register file discards writes to XZR. RdOut=31 and regWR still pulse.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset, then MUL A=7, B=6, Rd=3: busy rises the cycle after accept; done=regWR=1 exactly 65 cycles after accept edge; result=42, RdOut=3; done low on the next cycle.
- MUL A=0xFFFFFFFFFFFFFFFF (-1), B=5 -> result=0xFFFFFFFFFFFFFFFB. MUL A=2^32, B=2^32 -> result=0 (low-half truncation).
- UDIV A=100, B=7 -> 14. SDIV A=-100, B=7 -> 0xFFFFFFFFFFFFFFF2 (-14). SDIV A=0x8000000000000000, B=-1 -> 0x8000000000000000. UDIV A=5, B=0 -> 0. All with 65-cycle latency.
- start held high continuously with changing operands: exactly one accept per 66-cycle window; the second request starts the cycle after done; results match operands sampled at each accept edge.
- Assert rst at RUN cycle 30: next cycle busy=0, result=0, RdOut=0; no done/regWR pulse afterwards. A new start immediately after rst completes normally.
- Op 11 with Rd=31, A=9, B=9: done/regWR pulse at cycle 65 with result=0, RdOut=31. In a combined bench with the register file, register 31 reads 0 afterwards.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Issue/write-back bundle between the LEGv8 datapath and the
// iterative multiply/divide unit.
interface muldiv_unit_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] dataRn;
    logic [WIDTH-1:0] dataRm;
    logic [4:0]       Rd;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [4:0]       RdOut;
    logic             regWR;

    modport master (
        output start, op, dataRn, dataRm, Rd,
        input  busy, done, result, RdOut, regWR
    );

    modport slave (
        input  start, op, dataRn, dataRm, Rd,
        output busy, done, result, RdOut, regWR
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MUL/UDIV/SDIV unit: one bit per cycle, fixed latency,
// registered result/Rd/regWR feeding the register-file write port.
module muldiv_unit #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 6
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_UDIV = 2'b01;
    localparam logic [1:0] OP_SDIV = 2'b10;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t stateNext;

    logic [1:0]       opReg;
    logic [WIDTH-1:0] regA;
    logic [WIDTH-1:0] regB;
    logic [WIDTH-1:0] acc;
    logic             negQ;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] resultReg;
    logic [4:0]       rdReg;

    logic [WIDTH-1:0] absRn;
    logic [WIDTH-1:0] absRm;
    logic [WIDTH-1:0] mulAcc;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] divRem;
    logic [WIDTH-1:0] divQuo;
    logic [WIDTH-1:0] finalVal;
    logic             divZero;

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: if (bus.start) stateNext = RUN;
            RUN:  if (cnt == LAST) stateNext = DONE;
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // SDIV runs the unsigned datapath on magnitudes; sign fixed at the end
    always_comb begin
        absRn = bus.dataRn;
        absRm = bus.dataRm;
        if (bus.op == OP_SDIV && bus.dataRn[WIDTH-1]) absRn = '0 - bus.dataRn;
        if (bus.op == OP_SDIV && bus.dataRm[WIDTH-1]) absRm = '0 - bus.dataRm;
    end

    always_comb begin
        mulAcc  = acc + (regB[0] ? regA : '0);
        shifted = {acc, regA[WIDTH-1]};
        ge      = shifted >= {1'b0, regB};
        divRem  = ge ? (shifted[WIDTH-1:0] - regB) : shifted[WIDTH-1:0];
        divQuo  = {regA[WIDTH-2:0], ge};
        divZero = (regB == '0);
        finalVal = '0;
        unique case (opReg)
            OP_MUL:  finalVal = mulAcc;
            OP_UDIV: finalVal = divZero ? '0 : divQuo;
            OP_SDIV: begin
                if (!divZero) finalVal = negQ ? ('0 - divQuo) : divQuo;
            end
            default: finalVal = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            opReg     <= '0;
            regA      <= '0;
            regB      <= '0;
            acc       <= '0;
            negQ      <= 1'b0;
            cnt       <= '0;
            resultReg <= '0;
            rdReg     <= '0;
        end else begin
            state <= stateNext;
            if (state == IDLE && bus.start) begin
                opReg <= bus.op;
                regA  <= absRn;
                regB  <= absRm;
                acc   <= '0;
                cnt   <= '0;
                negQ  <= bus.dataRn[WIDTH-1] ^ bus.dataRm[WIDTH-1];
                rdReg <= bus.Rd;
            end else if (state == RUN) begin
                cnt <= cnt + 1'b1;
                unique case (opReg)
                    OP_MUL: begin
                        acc  <= mulAcc;
                        regA <= regA << 1;
                        regB <= regB >> 1;
                    end
                    OP_UDIV, OP_SDIV: begin
                        acc  <= divRem;
                        regA <= divQuo;
                    end
                    default: ;
                endcase
                if (cnt == LAST) resultReg <= finalVal;
            end
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.regWR  = (state == DONE);
    assign bus.result = resultReg;
    assign bus.RdOut  = rdReg;
endmodule
